// File: rtl/buffer_out_fifo.sv
// rtl/buffer_out_fifo.sv - first-word fall-through FIFO behind the buffer output stage
module buffer_out_fifo #(
    parameter int N     = 32,
    parameter int DEPTH = 4,
    parameter int AW    = $clog2(DEPTH)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic [N-1:0]  in_data,
    input  logic          in_en,
    input  logic          clr_ovf,
    output logic [N-1:0]  out_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic          full,
    output logic          empty,
    output logic [AW:0]   level,
    output logic          ovf
);

    logic [N-1:0]  mem [DEPTH];
    logic [AW-1:0] wr_ptr;
    logic [AW-1:0] rd_ptr;
    logic          rd;
    logic          wr;
    logic          drop;

    assign full      = (level == (AW+1)'(DEPTH));
    assign empty     = (level == '0);
    assign out_valid = ~empty;

    assign rd   = out_valid & out_ready;
    assign wr   = in_en & (~full | rd);
    assign drop = in_en & full & ~rd;

    // Gated to zero so nothing stale is ever presented while the queue is empty.
    assign out_data = out_valid ? mem[rd_ptr] : '0;

    always_ff @(posedge clk) begin
        if (wr) begin
            mem[wr_ptr] <= in_data;
        end
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            wr_ptr <= '0;
            rd_ptr <= '0;
            level  <= '0;
            ovf    <= 1'b0;
        end else begin
            if (wr) begin
                wr_ptr <= wr_ptr + 1'b1;
            end
            if (rd) begin
                rd_ptr <= rd_ptr + 1'b1;
            end
            if (wr && !rd) begin
                level <= level + 1'b1;
            end else if (rd && !wr) begin
                level <= level - 1'b1;
            end
            // A fresh drop outranks a simultaneous clear.
            if (drop) begin
                ovf <= 1'b1;
            end else if (clr_ovf) begin
                ovf <= 1'b0;
            end
        end
    end

endmodule

// File: tb/tb_buffer_out_fifo.sv
// tb/tb_buffer_out_fifo.sv - scoreboard bench for buffer_out_fifo
module tb_buffer_out_fifo;

    localparam int N     = 32;
    localparam int DEPTH = 4;
    localparam int AW    = 2;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic [N-1:0]  in_data = '0;
    logic          in_en = 1'b0;
    logic          clr_ovf = 1'b0;
    logic [N-1:0]  out_data;
    logic          out_valid;
    logic          out_ready = 1'b0;
    logic          full;
    logic          empty;
    logic [AW:0]   level;
    logic          ovf;

    int compared   = 0;
    int mismatched = 0;
    logic [N-1:0] sb[$];

    buffer_out_fifo #(.N(N), .DEPTH(DEPTH)) dut (
        .clk(clk), .rst(rst), .in_data(in_data), .in_en(in_en), .clr_ovf(clr_ovf),
        .out_data(out_data), .out_valid(out_valid), .out_ready(out_ready),
        .full(full), .empty(empty), .level(level), .ovf(ovf)
    );

    always #5 clk = ~clk;

    task automatic chk(input string name, input logic [N-1:0] act, input logic [N-1:0] exp);
        compared++;
        if (act !== exp) begin
            mismatched++;
            $display("FAIL %s: got 0x%0h expected 0x%0h at %0t", name, act, exp, $time);
        end
    endtask

    // Monitor: every handshake must match the oldest expected word.
    always @(negedge clk) begin
        if (!rst && out_valid === 1'b1 && out_ready === 1'b1) begin
            if (sb.size() == 0) begin
                compared++;
                mismatched++;
                $display("FAIL unexpected_word: got 0x%0h expected none at %0t", out_data, $time);
            end else begin
                chk("out_word", out_data, sb.pop_front());
            end
        end
    end

    // Apply inputs for one cycle, then return #1 after the capturing edge.
    task automatic cycle(input logic en, input logic [N-1:0] d, input logic rdy, input logic clr);
        in_en     = en;
        in_data   = d;
        out_ready = rdy;
        clr_ovf   = clr;
        @(posedge clk);
        #1;
    endtask

    task automatic push_write(input logic [N-1:0] d, input logic rdy);
        sb.push_back(d);
        cycle(1'b1, d, rdy, 1'b0);
    endtask

    task automatic fill4();
        push_write(32'h11, 1'b0);
        push_write(32'h22, 1'b0);
        push_write(32'h33, 1'b0);
        push_write(32'h44, 1'b0);
    endtask

    task automatic drain(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, $urandom, 1'b1, 1'b0);
    endtask

    initial begin
        // Reset held with random inputs
        for (int i = 0; i < 5; i++) begin
            in_en = 1'(($urandom));
            in_data = $urandom;
            out_ready = 1'(($urandom));
            clr_ovf = 1'(($urandom));
            @(posedge clk);
            #1;
            chk("rst_level", level, 0);
            chk("rst_empty", empty, 1);
            chk("rst_full", full, 0);
            chk("rst_valid", out_valid, 0);
            chk("rst_data", out_data, 0);
            chk("rst_ovf", ovf, 0);
        end
        cycle(1'b0, 0, 1'b0, 1'b0);
        rst = 1'b0;
        cycle(1'b0, 0, 1'b0, 1'b0);

        // Fill and drain
        push_write(32'h11, 1'b0); chk("fill_level1", level, 1);
        chk("fill_head", out_data, 32'h11);
        push_write(32'h22, 1'b0); chk("fill_level2", level, 2);
        push_write(32'h33, 1'b0); chk("fill_level3", level, 3);
        push_write(32'h44, 1'b0); chk("fill_level4", level, 4);
        chk("fill_full", full, 1);
        cycle(1'b0, 32'hdead, 1'b0, 1'b0);
        chk("hold_data", out_data, 32'h11);
        drain(4);
        chk("drain_empty", empty, 1);
        chk("drain_level", level, 0);

        // Overflow drops the word and sets sticky flag
        fill4();
        cycle(1'b1, 32'h55, 1'b0, 1'b0);
        chk("ovf_set", ovf, 1);
        chk("ovf_level", level, 4);
        drain(4);
        chk("ovf_sticky", ovf, 1);
        chk("ovf_drained", empty, 1);
        cycle(1'b0, 0, 1'b0, 1'b1);
        chk("ovf_clr", ovf, 0);

        // Set wins over simultaneous clear
        fill4();
        cycle(1'b1, 32'h66, 1'b0, 1'b1);
        chk("ovf_set_wins", ovf, 1);
        cycle(1'b0, 0, 1'b0, 1'b1);
        chk("ovf_clr2", ovf, 0);

        // Full pass-through
        push_write(32'hAA, 1'b1);
        chk("pass_level", level, 4);
        chk("pass_ovf", ovf, 0);
        drain(4);
        chk("pass_empty", empty, 1);

        // Wrap-around at level 1
        push_write(32'd1, 1'b0);
        for (int i = 2; i <= 10; i++) begin
            push_write(32'(i), 1'b1);
            chk("wrap_level", level, 1);
        end
        drain(1);
        chk("wrap_empty", empty, 1);

        // Reset mid-operation
        push_write(32'h01, 1'b0);
        push_write(32'h02, 1'b0);
        push_write(32'h03, 1'b0);
        chk("mid_level3", level, 3);
        rst = 1'b1;
        #1;
        chk("mid_rst_level", level, 0);
        chk("mid_rst_valid", out_valid, 0);
        chk("mid_rst_data", out_data, 0);
        sb.delete();
        cycle(1'b0, 0, 1'b0, 1'b0);
        rst = 1'b0;
        cycle(1'b0, 0, 1'b0, 1'b0);
        push_write(32'h77, 1'b1);
        chk("post_rst_data", out_data, 32'h77);
        chk("post_rst_level", level, 1);
        drain(1);
        chk("final_empty", empty, 1);
        chk("sb_left", 32'(sb.size()), 0);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
        $finish;
    end

    initial begin
        #20000;
        $display("FAIL watchdog: got timeout expected completion");
        $fatal(1, "watchdog");
    end

endmodule
